// File: rtl/rr_bypass_stage_if.sv
// Bundle of the register-read stage's handshake, bypass, register-file write and status signals.
// The slave modport is the stage itself; the master modport is whatever drives it.
interface rr_bypass_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int PW   = 64
);
    logic                 flush;

    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        in_src1;
    logic [AW-1:0]        in_src2;
    logic                 in_src1_en;
    logic                 in_src2_en;
    logic [AW-1:0]        in_dest;
    logic [PW-1:0]        in_payload;

    logic [NSTG-1:0]      prod_valid;
    logic [NSTG-1:0]      prod_we;
    logic [NSTG*AW-1:0]   prod_dest;
    logic [NSTG*XLEN-1:0] prod_data;
    logic [NSTG-1:0]      prod_data_ok;

    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_src1_val;
    logic [XLEN-1:0]      out_src2_val;
    logic [AW-1:0]        out_dest;
    logic [PW-1:0]        out_payload;

    logic [31:0]          stall_cnt;

    modport slave (
        input  flush,
        input  in_valid, in_src1, in_src2, in_src1_en, in_src2_en, in_dest, in_payload,
        output in_ready,
        input  prod_valid, prod_we, prod_dest, prod_data, prod_data_ok,
        input  rf_we, rf_waddr, rf_wdata,
        output out_valid, out_src1_val, out_src2_val, out_dest, out_payload,
        input  out_ready,
        output stall_cnt
    );

    modport master (
        output flush,
        output in_valid, in_src1, in_src2, in_src1_en, in_src2_en, in_dest, in_payload,
        input  in_ready,
        output prod_valid, prod_we, prod_dest, prod_data, prod_data_ok,
        output rf_we, rf_waddr, rf_wdata,
        input  out_valid, out_src1_val, out_src2_val, out_dest, out_payload,
        output out_ready,
        input  stall_cnt
    );
endinterface

// File: rtl/rr_bypass_stage.sv
// Register-read stage: one instruction slot, an internal 2R/1W register file, and operand
// bypassing from NSTG downstream producer stages; stalls only on a not-yet-ready youngest match.
module rr_bypass_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int PW   = 64
) (
    input logic               clk,
    input logic               reset,
    rr_bypass_stage_if.slave  bus
);
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic            haz;
        logic [XLEN-1:0] val;
    } resolve_t;

    logic [XLEN-1:0] rf_q [NREG];

    logic            v_q, v_d;
    logic [AW-1:0]   src1_q, src2_q;
    logic            src1En_q, src2En_q;
    logic [AW-1:0]   dest_q;
    logic [PW-1:0]   payload_q;
    logic [31:0]     stallCnt_q, stallCnt_d;

    logic [XLEN-1:0] rfRd1, rfRd2;
    resolve_t        res1, res2;
    logic            go;
    logic            inReady;
    logic            load;

    // Write-first read: a same-cycle write to the addressed register is forwarded.
    function automatic logic [XLEN-1:0] rfRead(
        input logic [AW-1:0]   idx,
        input logic            we,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] r;
        r = stored;
        if (idx == '0) begin
            r = '0;
        end else if (we && waddr == idx) begin
            r = wdata;
        end
        return r;
    endfunction

    // Only the youngest matching producer counts; an older stage never masks its hazard.
    function automatic resolve_t resolveSrc(
        input logic [AW-1:0]        idx,
        input logic                 en,
        input logic [XLEN-1:0]      rfVal,
        input logic [NSTG-1:0]      pValid,
        input logic [NSTG-1:0]      pWe,
        input logic [NSTG*AW-1:0]   pDest,
        input logic [NSTG*XLEN-1:0] pData,
        input logic [NSTG-1:0]      pOk
    );
        resolve_t r;
        logic     found;
        r.haz = 1'b0;
        r.val = rfVal;
        found = 1'b0;
        if (en && idx != '0) begin
            for (int i = 0; i < NSTG; i++) begin
                if (!found && pValid[i] && pWe[i] && pDest[i*AW +: AW] == idx) begin
                    found = 1'b1;
                    if (pOk[i]) begin
                        r.val = pData[i*XLEN +: XLEN];
                    end else begin
                        r.haz = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (bus.rf_we && bus.rf_waddr != '0) begin
            rf_q[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    always_comb begin
        rfRd1 = rfRead(src1_q, bus.rf_we, bus.rf_waddr, bus.rf_wdata, rf_q[src1_q]);
        rfRd2 = rfRead(src2_q, bus.rf_we, bus.rf_waddr, bus.rf_wdata, rf_q[src2_q]);
        res1  = resolveSrc(src1_q, src1En_q, rfRd1, bus.prod_valid, bus.prod_we,
                           bus.prod_dest, bus.prod_data, bus.prod_data_ok);
        res2  = resolveSrc(src2_q, src2En_q, rfRd2, bus.prod_valid, bus.prod_we,
                           bus.prod_dest, bus.prod_data, bus.prod_data_ok);
    end

    always_comb begin
        go         = !res1.haz && !res2.haz;
        inReady    = !v_q || (go && bus.out_ready);
        load       = bus.in_valid && inReady && !bus.flush;
        v_d        = v_q;
        stallCnt_d = stallCnt_q;
        // Flush wins over both the upstream load and the downstream handshake.
        if (bus.flush) begin
            v_d = 1'b0;
        end else if (inReady) begin
            v_d = bus.in_valid;
        end
        if (v_q && !go && !bus.flush) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q        <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            v_q        <= v_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            src1_q    <= bus.in_src1;
            src2_q    <= bus.in_src2;
            src1En_q  <= bus.in_src1_en;
            src2En_q  <= bus.in_src2_en;
            dest_q    <= bus.in_dest;
            payload_q <= bus.in_payload;
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = v_q && go;
    assign bus.out_src1_val = res1.val;
    assign bus.out_src2_val = res2.val;
    assign bus.out_dest     = dest_q;
    assign bus.out_payload  = payload_q;
    assign bus.stall_cnt    = stallCnt_q;
endmodule

// File: tb/tb_rr_bypass_stage.sv
// Self-checking bench for rr_bypass_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rr_bypass_stage;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSTG = 3;
    localparam int PW   = 64;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic reset;
    int   passCount  = 0;
    int   checkCount = 0;
    bit   modelKnown = 0;

    rr_bypass_stage_if #(.XLEN(XLEN), .AW(AW), .NSTG(NSTG), .PW(PW)) bus ();

    rr_bypass_stage #(.XLEN(XLEN), .AW(AW), .NSTG(NSTG), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] mRf [NREG];
    bit              mV;
    logic [AW-1:0]   mSrc1, mSrc2, mDest;
    bit              mEn1, mEn2;
    logic [PW-1:0]   mPay;
    int unsigned     mCnt;

    logic [XLEN-1:0] eVal1, eVal2;
    bit              eHaz1, eHaz2, eGo, eOutValid, eInReady;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [XLEN-1:0] modelRfRead(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (bus.rf_we && bus.rf_waddr == idx) return bus.rf_wdata;
        return mRf[idx];
    endfunction

    // Collect every producer holding this register, then let the youngest decide.
    task automatic modelResolve(input logic [AW-1:0] idx, input bit en,
                                output logic [XLEN-1:0] val, output bit haz);
        int hits[$];
        val = modelRfRead(idx);
        haz = 0;
        if (!en || idx == 0) return;
        for (int i = 0; i < NSTG; i++)
            if (bus.prod_valid[i] && bus.prod_we[i] && bus.prod_dest[i*AW +: AW] == idx)
                hits.push_back(i);
        if (hits.size() == 0) return;
        if (bus.prod_data_ok[hits[0]]) val = bus.prod_data[hits[0]*XLEN +: XLEN];
        else haz = 1;
    endtask

    task automatic checkOutput();
        modelResolve(mSrc1, mEn1, eVal1, eHaz1);
        modelResolve(mSrc2, mEn2, eVal2, eHaz2);
        eGo       = !eHaz1 && !eHaz2;
        eOutValid = mV && eGo;
        eInReady  = !mV || (eGo && bus.out_ready);
        if (!modelKnown) return;
        checkVal("out_valid", {63'd0, bus.out_valid}, {63'd0, eOutValid});
        checkVal("in_ready", {63'd0, bus.in_ready}, {63'd0, eInReady});
        checkVal("stall_cnt", {32'd0, bus.stall_cnt}, {32'd0, mCnt});
        if (eOutValid) begin
            checkVal("src1_val", {32'd0, bus.out_src1_val}, {32'd0, eVal1});
            checkVal("src2_val", {32'd0, bus.out_src2_val}, {32'd0, eVal2});
            checkVal("dest", {59'd0, bus.out_dest}, {59'd0, mDest});
            checkVal("payload", bus.out_payload, mPay);
        end
    endtask

    task automatic modelUpdate();
        if (reset) begin
            mV         = 0;
            mCnt       = 0;
            modelKnown = 1;
        end else begin
            if (mV && !eGo && !bus.flush) mCnt++;
            if (bus.in_valid && eInReady) begin
                mSrc1 = bus.in_src1;
                mSrc2 = bus.in_src2;
                mEn1  = bus.in_src1_en;
                mEn2  = bus.in_src2_en;
                mDest = bus.in_dest;
                mPay  = bus.in_payload;
            end
            if (bus.flush) mV = 0;
            else if (eInReady) mV = bus.in_valid;
        end
        if (bus.rf_we && bus.rf_waddr != 0) mRf[bus.rf_waddr] = bus.rf_wdata;
    endtask

    task automatic settle();
        #1;
        checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        bus.flush        = 0;
        bus.in_valid     = 0;
        bus.in_src1      = '0;
        bus.in_src2      = '0;
        bus.in_src1_en   = 0;
        bus.in_src2_en   = 0;
        bus.in_dest      = '0;
        bus.in_payload   = '0;
        bus.prod_valid   = '0;
        bus.prod_we      = '0;
        bus.prod_dest    = '0;
        bus.prod_data    = '0;
        bus.prod_data_ok = '0;
        bus.rf_we        = 0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        bus.out_ready    = 1;
    endtask

    task automatic loadSlot(input logic [AW-1:0] s1, input bit e1, input logic [AW-1:0] s2,
                            input bit e2, input logic [AW-1:0] d, input logic [PW-1:0] p);
        idleInputs();
        bus.in_valid   = 1;
        bus.in_src1    = s1;
        bus.in_src1_en = e1;
        bus.in_src2    = s2;
        bus.in_src2_en = e2;
        bus.in_dest    = d;
        bus.in_payload = p;
        settle();
        clockEdge();
        idleInputs();
    endtask

    task automatic setProducer(input int i, input logic [AW-1:0] d, input logic [XLEN-1:0] data,
                               input bit ok);
        bus.prod_valid[i]            = 1;
        bus.prod_we[i]               = 1;
        bus.prod_dest[i*AW +: AW]    = d;
        bus.prod_data[i*XLEN +: XLEN] = data;
        bus.prod_data_ok[i]          = ok;
    endtask

    task automatic applyStimulus();
        bus.flush      = ($urandom_range(0, 19) == 0);
        bus.in_valid   = ($urandom_range(0, 9) < 7);
        bus.in_src1    = AW'($urandom_range(0, 7));
        bus.in_src2    = AW'($urandom_range(0, 7));
        bus.in_src1_en = ($urandom_range(0, 7) != 0);
        bus.in_src2_en = ($urandom_range(0, 7) != 0);
        bus.in_dest    = AW'($urandom_range(0, 7));
        bus.in_payload = {$urandom, $urandom};
        for (int i = 0; i < NSTG; i++) begin
            bus.prod_valid[i]             = $urandom_range(0, 1);
            bus.prod_we[i]                = ($urandom_range(0, 3) != 0);
            bus.prod_dest[i*AW +: AW]     = AW'($urandom_range(0, 7));
            bus.prod_data[i*XLEN +: XLEN] = $urandom;
            bus.prod_data_ok[i]           = ($urandom_range(0, 3) != 0);
        end
        bus.rf_we     = $urandom_range(0, 1);
        bus.rf_waddr  = AW'($urandom_range(0, 7));
        bus.rf_wdata  = $urandom;
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int unsigned c0;
        idleInputs();
        reset = 1;
        repeat (2) begin settle(); clockEdge(); end
        reset = 0;

        for (int r = 1; r < NREG; r++) begin
            idleInputs();
            bus.rf_we    = 1;
            bus.rf_waddr = AW'(r);
            bus.rf_wdata = $urandom;
            settle();
            clockEdge();
        end

        // Register file read with no producers active.
        idleInputs();
        bus.rf_we = 1; bus.rf_waddr = 5; bus.rf_wdata = 32'h1234;
        settle();
        clockEdge();
        loadSlot(5, 1, 0, 1, 9, 64'h0123_4567_89AB_CDEF);
        settle();
        checkVal("rf_out_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("rf_src1", {32'd0, bus.out_src1_val}, 64'h1234);
        checkVal("rf_src2", {32'd0, bus.out_src2_val}, 64'h0);
        clockEdge();

        // Youngest match wins, then a stalled youngest match blocks older data.
        loadSlot(7, 1, 0, 0, 1, 64'h11);
        setProducer(0, 7, 32'hA, 1);
        setProducer(2, 7, 32'hB, 1);
        bus.out_ready = 0;
        settle();
        checkVal("prio_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("prio_src1", {32'd0, bus.out_src1_val}, 64'hA);
        clockEdge();
        bus.prod_data_ok[0] = 0;
        c0 = mCnt;
        settle();
        checkVal("haz_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("haz_ready", {63'd0, bus.in_ready}, 64'd0);
        clockEdge();
        settle();
        checkVal("haz_cnt1", {32'd0, bus.stall_cnt}, {32'd0, c0 + 1});
        clockEdge();
        // Load-use: producer advances to stage 1 with its result ready.
        idleInputs();
        setProducer(1, 7, 32'h55, 1);
        settle();
        checkVal("lu_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("lu_src1", {32'd0, bus.out_src1_val}, 64'h55);
        checkVal("lu_cnt", {32'd0, bus.stall_cnt}, {32'd0, c0 + 2});
        clockEdge();

        loadSlot(3, 1, 0, 0, 2, 64'h22);
        bus.rf_we = 1; bus.rf_waddr = 3; bus.rf_wdata = 32'h99;
        settle();
        checkVal("wfirst_src1", {32'd0, bus.out_src1_val}, 64'h99);
        clockEdge();

        loadSlot(0, 0, 0, 1, 2, 64'h33);
        setProducer(0, 0, 32'hFFFF, 0);
        settle();
        checkVal("zero_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("zero_ready", {63'd0, bus.in_ready}, 64'd1);
        checkVal("zero_src2", {32'd0, bus.out_src2_val}, 64'h0);
        clockEdge();

        // Backpressure holds everything, then flush drops the slot and the incoming one.
        loadSlot(5, 1, 3, 1, 4, 64'hDEAD_BEEF_0000_1111);
        repeat (3) begin
            bus.out_ready = 0;
            settle();
            checkVal("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            checkVal("bp_src1", {32'd0, bus.out_src1_val}, 64'h1234);
            checkVal("bp_src2", {32'd0, bus.out_src2_val}, 64'h99);
            checkVal("bp_payload", bus.out_payload, 64'hDEAD_BEEF_0000_1111);
            clockEdge();
        end
        bus.flush = 1; bus.in_valid = 1; bus.in_src1 = 1; bus.in_src1_en = 1;
        settle();
        clockEdge();
        idleInputs();
        settle();
        checkVal("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("flush_ready", {63'd0, bus.in_ready}, 64'd1);
        clockEdge();

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            settle();
            clockEdge();
        end

        // Reset while stalled drops the slot and clears the counter.
        idleInputs();
        settle();
        clockEdge();
        loadSlot(7, 1, 0, 0, 1, 64'h44);
        setProducer(0, 7, 32'h77, 0);
        settle();
        clockEdge();
        reset = 1;
        settle();
        clockEdge();
        reset = 0;
        settle();
        checkVal("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        checkVal("rst_cnt", {32'd0, bus.stall_cnt}, 64'd0);
        clockEdge();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
